// File: rtl/mpc_prod_accum.sv
// Streaming dot-product accumulator behind the MPC multiplier: sums products per vector, then rounds, rescales and clips to Q21.
// Optional output clipping is enabled by defining MPC_ACC_SAT_EN; otherwise the result wraps.
module mpc_prod_accum #(
    parameter int unsigned PW        = 36,
    parameter int unsigned AW        = 44,
    parameter int unsigned OW        = 21,
    parameter int unsigned SHIFT     = 14,
    parameter int unsigned MAX_TERMS = 256
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ce,
    input  logic          in_valid,
    input  logic          in_last,
    input  logic [PW-1:0] in_p,
    output logic          out_valid,
    output logic [OW-1:0] out_data,
    output logic          out_sat,
    output logic          out_err,
    output logic          busy
);

    localparam int unsigned CW = $clog2(MAX_TERMS + 1);
    localparam logic signed [AW:0] HALF = (AW+1)'(1) << (SHIFT - 1);
    localparam logic signed [AW:0] OMAX = (AW+1)'((1 << (OW - 1)) - 1);
    localparam logic signed [AW:0] OMIN = ~OMAX;

    typedef enum logic {
        IDLE = 1'b0,
        ACC  = 1'b1
    } state_t;

    state_t               state;
    logic signed [AW-1:0] acc;
    logic [CW-1:0]        cnt;
    logic                 fin;
    logic                 err;

    logic                 first_c;
    logic                 term_c;
    logic signed [AW-1:0] sext_c;
    logic signed [AW:0]   rnd_c;
    logic signed [AW:0]   shf_c;
    logic [OW-1:0]        data_c;
    logic                 sat_c;

    // A fresh vector starts from zero so no stale sum carries over.
    always_comb begin
        first_c = (state == IDLE);
        term_c  = in_last || (cnt == CW'(MAX_TERMS - 1));
        sext_c  = {{(AW - PW){in_p[PW-1]}}, in_p};
    end

    // Round half-up at AW+1 bits, drop the fractional bits, then clip or wrap.
    always_comb begin
        rnd_c  = {acc[AW-1], acc} + HALF;
        shf_c  = rnd_c >>> SHIFT;
        data_c = OW'(shf_c);
        sat_c  = 1'b0;
`ifdef MPC_ACC_SAT_EN
        if (shf_c > OMAX) begin
            data_c = OW'(OMAX);
            sat_c  = 1'b1;
        end else if (shf_c < OMIN) begin
            data_c = OW'(OMIN);
            sat_c  = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            acc       <= '0;
            cnt       <= '0;
            fin       <= 1'b0;
            err       <= 1'b0;
            busy      <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sat   <= 1'b0;
            out_err   <= 1'b0;
        end else if (ce) begin
            fin <= 1'b0;
            if (in_valid) begin
                acc <= (first_c ? '0 : acc) + sext_c;
                if (term_c) begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    cnt   <= '0;
                    fin   <= 1'b1;
                    err   <= !in_last;
                end else begin
                    state <= ACC;
                    busy  <= 1'b1;
                    cnt   <= cnt + CW'(1);
                end
            end
            // Output stage consumes the sum finalised on the previous ce-edge.
            out_valid <= fin;
            if (fin) begin
                out_data <= data_c;
                out_sat  <= sat_c;
                out_err  <= err;
            end
        end
    end

endmodule

// File: tb/tb_mpc_prod_accum.sv
// Scoreboard bench for mpc_prod_accum: driver feeds terms and a queue-based reference model; monitor checks each result.
module tb_mpc_prod_accum;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ce = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_last = 1'b0;
    logic [35:0] in_p = '0;
    logic        out_valid;
    logic [20:0] out_data;
    logic        out_sat;
    logic        out_err;
    logic        busy;

    int total = 0;
    int bad = 0;
    int ce_mode = 0;   // 0: always on, 1: toggle, 2: random

    typedef struct {
        logic [20:0] d;
        logic        sat;
        logic        err;
    } exp_t;

    exp_t   sb[$];
    longint cur[$];

    mpc_prod_accum dut (
        .clk(clk), .rst(rst), .ce(ce), .in_valid(in_valid), .in_last(in_last), .in_p(in_p),
        .out_valid(out_valid), .out_data(out_data), .out_sat(out_sat), .out_err(out_err), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic void check(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endfunction

    // Reference: sum the vector, round half-up, rescale, then clip or wrap.
    function automatic void close_vector(input logic forced);
        longint s = 0;
        longint r;
        exp_t   e;
        foreach (cur[i]) s += cur[i];
        r = (s + 64'sd8192) >>> 14;
        e.sat = 1'b0;
`ifdef MPC_ACC_SAT_EN
        if (r > 64'sd1048575) begin r = 64'sd1048575; e.sat = 1'b1; end
        else if (r < -64'sd1048576) begin r = -64'sd1048576; e.sat = 1'b1; end
`endif
        e.d   = 21'(r);
        e.err = forced;
        sb.push_back(e);
        cur.delete();
    endfunction

    function automatic void model_take(input longint v, input logic last);
        cur.push_back(v);
        if (last) close_vector(1'b0);
        else if (cur.size() == 256) close_vector(1'b1);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
        case (ce_mode)
            1:       ce = ~ce;
            2:       ce = ($urandom_range(3) != 0);
            default: ce = 1'b1;
        endcase
    endtask

    task automatic term(input longint v, input logic last);
        logic took;
        in_valid = 1'b1;
        in_p     = 36'(v);
        in_last  = last;
        do begin
            took = ce;
            step();
        end while (!took);
        in_valid = 1'b0;
        in_last  = 1'b0;
        model_take(v, last);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            in_last = 1'($urandom);
            step();
        end
        in_last = 1'b0;
    endtask

    // Monitor: a result is consumed on the edge where out_valid and ce are both high.
    always @(negedge clk) begin
        if (!rst && ce && out_valid) begin
            if (sb.size() == 0) begin
                check("unexpected_out_valid", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("out_data", longint'($signed(out_data)), longint'($signed(e.d)));
                check("out_sat", longint'(out_sat), longint'(e.sat));
                check("out_err", longint'(out_err), longint'(e.err));
            end
        end
    end

    initial begin
        int wait_cnt;
        step();
        step();
        check("rst_out_valid", longint'(out_valid), 0);
        check("rst_out_data", longint'(out_data), 0);
        check("rst_out_sat", longint'(out_sat), 0);
        check("rst_out_err", longint'(out_err), 0);
        check("rst_busy", longint'(busy), 0);
        rst = 1'b0;
        step();

        // Basic three-term vector, then busy must show partial accumulation.
        term(16384, 1'b0);
        check("busy_after_first", longint'(busy), 1);
        term(16384, 1'b0);
        term(16384, 1'b1);
        check("busy_after_last", longint'(busy), 0);
        idle(3);

        // Rounding boundaries and saturation, back-to-back single-term vectors.
        term(8192, 1'b1);
        term(-8192, 1'b1);
        term(-8193, 1'b1);
        term(24575, 1'b1);
        term(longint'(1) << 34, 1'b1);
        term(-(longint'(1) << 35), 1'b1);
        idle(3);

        // ce toggling during a four-term vector.
        ce_mode = 1;
        for (int i = 0; i < 4; i++) term(16384, i == 3);
        idle(8);
        ce_mode = 0;
        idle(1);

        // Forced termination at 256 terms, then a normal two-term vector.
        for (int i = 0; i < 256; i++) term(16384, 1'b0);
        term(16384, 1'b0);
        term(16384, 1'b1);
        idle(4);

        // Reset mid-vector discards the partial sum.
        term(16384, 1'b0);
        term(16384, 1'b0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        cur.delete();
        check("busy_after_rst", longint'(busy), 0);
        check("out_valid_after_rst", longint'(out_valid), 0);
        term(16384, 1'b1);
        idle(4);

        // Randomised vectors with gaps and random ce.
        ce_mode = 2;
        for (int v = 0; v < 60; v++) begin
            int len = $urandom_range(1, 8);
            for (int t = 0; t < len; t++) begin
                longint p;
                if ($urandom_range(1) == 0)
                    p = longint'($signed(21'($urandom))) <<< 10;
                else
                    p = longint'($signed(36'({$urandom, $urandom})));
                term(p, t == len - 1);
                if ($urandom_range(3) == 0) idle($urandom_range(1, 3));
            end
            if ($urandom_range(1) == 0) idle($urandom_range(1, 2));
        end
        ce_mode = 0;

        wait_cnt = 0;
        while (sb.size() != 0 && wait_cnt < 50) begin
            step();
            wait_cnt++;
        end
        check("scoreboard_drained", longint'(sb.size()), 0);
        idle(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mpc_prod_accum.md
# mpc_prod_accum

Streaming accumulator that sits directly downstream of the MPC datapath's 21s×15s signed multiplier (4-cycle pipeline, 36-bit product). It sums a vector of products into one dot-product term, then rounds, rescales and saturates the sum back to the 21-bit Q-format used by the solver. It emits one result per vector with a single-cycle valid pulse. The upstream controller supplies `in_valid`/`in_last` already delayed to line up with the multiplier latency.

## Interface
- `PW`, 36: product input width (signed).
- `AW`, 44: accumulator width (signed); must be at least PW + clog2(MAX_TERMS).
- `OW`, 21: output width (signed).
- `SHIFT`, 14: fractional bits removed from the sum (Q of the 15-bit coefficient operand).
- `MAX_TERMS`, 256: maximum products per vector.
- `clk` in 1: clock. All logic is on the rising edge.
- `rst` in 1: reset. It is synchronous and active-high.
- `ce` in 1: clock enable, shared with the multiplier. While low, every register holds.
- `in_valid` in 1: `in_p` carries a product this cycle.
- `in_last` in 1: this product is the final term of its vector. Ignored unless `in_valid` is high.
- `in_p` in PW: signed product.
- `out_valid` out 1: `out_data` holds a new result. Pulse of one ce-qualified cycle.
- `out_data` out OW: rounded, shifted, saturated dot product.
- `out_sat` out 1: the result was clipped (valid with `out_valid`).
- `out_err` out 1: the vector was force-terminated at MAX_TERMS (valid with `out_valid`).
- `busy` out 1: a vector is partially accumulated.

## Operation
- Reset values: `acc` = 0, term count = 0, `first` = 1, `out_valid` = 0, `out_data` = 0, `out_sat` = 0, `out_err` = 0, `busy` = 0.
- Nothing changes in a cycle with `ce` = 0. `out_valid` holds its level, so consumers must qualify it with `ce`.
- State machine, two states:
  - **IDLE**: `first` = 1, `busy` = 0.
  - **ACC**: a partial sum is held, `busy` = 1.
  - IDLE → ACC on a valid term without `in_last`.
  - ACC → IDLE on a valid term with `in_last`, or when the MAX_TERMS-th term is taken.
  - Any state → IDLE on `rst`.
- On each accepted term:
  - `acc <= (first ? 0 : acc) + sext(in_p)`.
  - The count increments.
  - `first` is cleared.
- Terminal term: `in_last`, or count reaching MAX_TERMS.
  - Sets `first` = 1 and resets the count to 0.
  - Raises an internal `fin` flag for the next stage.
  - When the termination is forced (count hits MAX_TERMS without `in_last`), it also latches `err`. The following terms start a new vector.
- Output stage, on the ce-cycle after `fin`:
  - `r = (acc + 2^(SHIFT-1)) >>> SHIFT`. This is round-half-up (toward +inf), computed at AW+1 bits so there is no intermediate overflow.
  - `r` is then clipped to [−2^(OW−1), 2^(OW−1)−1].
  - The stage registers `out_data`, `out_sat` and `out_err`, and pulses `out_valid`.
- In cycles with `ce` = 1 and no `fin`, `out_valid` = 0. `out_data` keeps its last value.
- Back-to-back vectors are supported: the first term of the next vector may arrive in the cycle right after a terminal term. `first` guarantees that no stale sum carries over.
- A single-term vector (`in_valid` and `in_last` in the same cycle) is legal.
- Gaps inside a vector (`in_valid` = 0) leave `acc` unchanged.
- `rst` during ACC discards the partial sum. A pending `fin` is also dropped, so no `out_valid` follows.

## Timing
- Latency: terminal term sampled at ce-edge k → `acc` final after edge k → `out_valid`/`out_data` visible after ce-edge k+1. That is 2 ce-cycles from the terminal term.
- Throughput: one term per ce-cycle. One result per vector, minimum 1 cycle apart.
- End-to-end, from multiplier operands to result, is 4 + 2 = 6 ce-cycles for a one-term vector.

## Configuration
- `MPC_ACC_SAT_EN` defined: clip as described. `out_sat` = 1 when clipping occurred.
- Not defined: `out_data` = the low OW bits of `r` (two's-complement wrap). `out_sat` is tied to 0, and the comparators are removed.

## Test plan
- Three terms `in_p` = 16384, 16384, 16384, with `in_last` on the third → two cycles later `out_valid` = 1 for one cycle, `out_data` = 3, `out_sat` = 0.
- Rounding: single terms 8192 → 1; −8192 → 0; −8193 → −1; 24575 → 1.
- Saturation, single term 2^34:
  - With `MPC_ACC_SAT_EN`: `out_data` = 1048575, `out_sat` = 1.
  - Without it: `out_data` = −1048576, `out_sat` = 0.
  - A term of −2^35 with the macro gives −1048576, `out_sat` = 1.
- `ce` toggled 0/1 every other cycle during a four-term vector of 16384 each → `out_data` = 4. `out_valid` is asserted only across ce cycles and is never lost.
- 256 terms of 16384 without `in_last`, then 2 terms with `in_last` on the second:
  - First result: 256, `out_err` = 1.
  - Second result: 2, `out_err` = 0.
- `rst` pulsed after 2 terms of a vector, then the vector {16384 with `in_last`} → no output from the aborted vector. The next result is 1. `busy` is 0 in the cycle after reset.
